// File: rtl/div_issue_ctrl_if.sv
// Bus between the EX issue logic, the divide sequencer and the multi-cycle divider.
// The slave modport is the sequencer's view. The master modport is the view of the EX stage and the divider.
interface div_issue_ctrl_if #(
  parameter int XLEN = 32
);
  logic            valid_in;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_addr;
  logic            flush;
  logic            out_ready;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;
  logic            busy;
  logic            err_timeout;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic            div_signed;
  logic            div_start;
  logic            div_status;
  logic            div_finished;
  logic [XLEN-1:0] div_quotient;
  logic [XLEN-1:0] div_remainder;

  modport master (
    output valid_in, funct3, rs1_data, rs2_data, rd_addr, flush, out_ready,
    output div_status, div_finished, div_quotient, div_remainder,
    input  in_ready, result_valid, result, result_rd, busy, err_timeout,
    input  div_dividend, div_divisor, div_signed, div_start
  );

  modport slave (
    input  valid_in, funct3, rs1_data, rs2_data, rd_addr, flush, out_ready,
    input  div_status, div_finished, div_quotient, div_remainder,
    output in_ready, result_valid, result, result_rd, busy, err_timeout,
    output div_dividend, div_divisor, div_signed, div_start
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage divide sequencer. It resolves divide-by-zero and signed overflow locally.
// It starts the multi-cycle divider for all other ops and holds the result for EX/MEM.
module div_issue_ctrl #(
  parameter int XLEN        = 32,
  parameter int DIV_TIMEOUT = 40
) (
  input logic             clk,
  input logic             reset,
  div_issue_ctrl_if.slave bus
);

  localparam int              WD_W    = $clog2(DIV_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_TIMEOUT - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] dividend_r;
  logic [XLEN-1:0] divisor_r;
  logic [XLEN-1:0] result_r;
  logic [4:0]      rd_r;
  logic            rem_r;
  logic            div_signed_r;
  logic            div_start_r;
  logic            result_valid_r;
  logic            busy_r;
  logic            err_timeout_r;
  logic [WD_W-1:0] wd_r;

  logic            accept_s;
  logic            fast_s;
  logic [XLEN-1:0] fast_result_s;

  // Zero divisor, or signed INT_MIN / -1, never reaches the divider.
  function automatic logic is_fast(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    return (b == ZERO) || (!f3[0] && (a == INT_MIN) && (b == ALL_ONE));
  endfunction

  function automatic logic [XLEN-1:0] fast_value(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [XLEN-1:0] v;
    if (b == ZERO) begin
      v = f3[1] ? a : ALL_ONE;
    end else begin
      v = f3[1] ? ZERO : INT_MIN;
    end
    return v;
  endfunction

  // Accept decode and fast-path result, both evaluated on the raw EX inputs
  always_comb begin
    accept_s      = 1'b0;
    fast_s        = 1'b0;
    fast_result_s = ZERO;
    if (!busy_r && !bus.flush && bus.valid_in && bus.funct3[2]) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    fast_s        = is_fast(bus.funct3, bus.rs1_data, bus.rs2_data);
    fast_result_s = fast_value(bus.funct3, bus.rs1_data, bus.rs2_data);
  end

  // Sequencer FSM with watchdog; every output is a register updated here
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      dividend_r     <= ZERO;
      divisor_r      <= ZERO;
      result_r       <= ZERO;
      rd_r           <= 5'd0;
      rem_r          <= 1'b0;
      div_signed_r   <= 1'b0;
      div_start_r    <= 1'b0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      err_timeout_r  <= 1'b0;
      wd_r           <= {WD_W{1'b0}};
    end else begin
      div_start_r   <= 1'b0;
      err_timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            dividend_r <= bus.rs1_data;
            divisor_r  <= bus.rs2_data;
            rd_r       <= bus.rd_addr;
            rem_r      <= bus.funct3[1];
            busy_r     <= 1'b1;
            if (fast_s) begin
              result_r       <= fast_result_s;
              result_valid_r <= 1'b1;
              state_r        <= ST_HOLD;
            end else begin
              div_signed_r <= ~bus.funct3[0];
              div_start_r  <= 1'b1;
              state_r      <= ST_START;
            end
          end
        end
        ST_START: begin
          // The start pulse is already on the wire, so a flush here must still drain the divider
          wd_r    <= {WD_W{1'b0}};
          state_r <= bus.flush ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.div_finished) begin
            if (bus.flush) begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              result_r       <= rem_r ? bus.div_remainder : bus.div_quotient;
              result_valid_r <= 1'b1;
              state_r        <= ST_HOLD;
            end
          end else if (bus.flush) begin
            wd_r    <= {WD_W{1'b0}};
            state_r <= ST_DRAIN;
          end else if (wd_r == WD_LAST) begin
            err_timeout_r <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            wd_r <= wd_r + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (bus.div_finished) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (wd_r == WD_LAST) begin
            err_timeout_r <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            wd_r <= wd_r + 1'b1;
          end
        end
        ST_HOLD: begin
          // A flush and an out_ready in the same cycle both end up here; either way the result is gone
          if (bus.flush || bus.out_ready) begin
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            state_r        <= ST_IDLE;
          end
        end
        default: begin
          result_valid_r <= 1'b0;
          busy_r         <= 1'b0;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = !busy_r && !bus.flush && !reset;
  assign bus.busy         = busy_r;
  assign bus.result_valid = result_valid_r;
  assign bus.result       = result_r;
  assign bus.result_rd    = rd_r;
  assign bus.err_timeout  = err_timeout_r;
  assign bus.div_dividend = dividend_r;
  assign bus.div_divisor  = divisor_r;
  assign bus.div_signed   = div_signed_r;
  assign bus.div_start    = div_start_r;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl. A behavioural divider answers the start handshake.
// Results are checked against RV32M division semantics.
module tb_div_issue_ctrl;
  localparam int XLEN = 32;
  localparam int TMO  = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_issue_ctrl_if #(.XLEN(XLEN)) bus ();
  div_issue_ctrl #(.XLEN(XLEN), .DIV_TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Divider model: finishes div_lat cycles after it sees div_start
  int          div_lat = 33;
  logic        tie_off = 1'b0;
  int          dcnt;
  logic [31:0] dq, dr;

  always @(posedge clk) begin
    if (reset) begin
      dcnt <= 0; dq <= 32'd0; dr <= 32'd0;
    end else if (bus.div_start) begin
      dcnt <= div_lat;
      if (bus.div_divisor == 32'd0) begin
        dq <= 32'hFFFF_FFFF; dr <= bus.div_dividend;
      end else if (bus.div_signed && bus.div_dividend == 32'h8000_0000 && bus.div_divisor == 32'hFFFF_FFFF) begin
        dq <= bus.div_dividend; dr <= 32'd0;
      end else if (bus.div_signed) begin
        dq <= 32'($signed(bus.div_dividend) / $signed(bus.div_divisor));
        dr <= 32'($signed(bus.div_dividend) % $signed(bus.div_divisor));
      end else begin
        dq <= bus.div_dividend / bus.div_divisor;
        dr <= bus.div_dividend % bus.div_divisor;
      end
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end

  assign bus.div_finished  = (dcnt == 1) && !tie_off;
  assign bus.div_status    = (dcnt != 0);
  assign bus.div_quotient  = dq;
  assign bus.div_remainder = dr;

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
      return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f3[1] ? a % b : a / b;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.valid_in = 1'b1; bus.funct3 = f3; bus.rs1_data = a; bus.rs2_data = b; bus.rd_addr = rd;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  // Steps from the cycle after accept until result_valid, recording the start handshake
  task automatic wait_result(output int cyc, output int start_cyc, output int n_start, output logic sgn);
    cyc = 1; start_cyc = -1; n_start = 0; sgn = 1'b0;
    while (!bus.result_valid && cyc < 120) begin
      if (bus.div_start) begin n_start++; start_cyc = cyc; sgn = bus.div_signed; end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1; @(posedge clk); #1; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [106:0] obs;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs = {bus.in_ready, bus.result_valid, bus.busy, bus.err_timeout, bus.div_start, bus.div_signed,
           bus.result_rd, bus.result, bus.div_dividend, bus.div_divisor};
    n_tests++; if (obs !== 107'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({bus.in_ready, bus.busy} !== 2'b10) begin n_fail++; $display("FAIL reset_idle: in_ready/busy got %b expected 10", {bus.in_ready, bus.busy}); end
  endtask

  task automatic test_normal();
    logic [2:0]  f3 [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] a  [4] = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C};
    logic [31:0] ex [4] = '{32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE};
    int cyc, sc, ns; logic sgn;
    div_lat = 33;
    for (int i = 0; i < 4; i++) begin
      issue(f3[i], a[i], 32'd7, 5'(i + 3));
      wait_result(cyc, sc, ns, sgn);
      n_tests++; if (cyc !== 35) begin n_fail++; $display("FAIL normal_latency[%0d]: got %0d expected 35", i, cyc); end
      n_tests++; if (sc !== 1 || ns !== 1) begin n_fail++; $display("FAIL normal_start[%0d]: cycle %0d count %0d expected cycle 1 count 1", i, sc, ns); end
      n_tests++; if (sgn !== ~f3[i][0]) begin n_fail++; $display("FAIL normal_signed[%0d]: got %b expected %b", i, sgn, ~f3[i][0]); end
      n_tests++; if (bus.result !== ex[i]) begin n_fail++; $display("FAIL normal_result[%0d]: got %h expected %h", i, bus.result, ex[i]); end
      n_tests++; if (bus.result_rd !== 5'(i + 3)) begin n_fail++; $display("FAIL normal_rd[%0d]: got %0d expected %0d", i, bus.result_rd, i + 3); end
      take();
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  f3 [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] a  [4] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};
    int cyc, sc, ns; logic sgn;
    for (int i = 0; i < 4; i++) begin
      issue(f3[i], a[i], b[i], 5'(20 + i));
      wait_result(cyc, sc, ns, sgn);
      n_tests++; if (cyc !== 1 || ns !== 0) begin n_fail++; $display("FAIL fast_timing[%0d]: valid at %0d starts %0d expected 1 and 0", i, cyc, ns); end
      n_tests++; if (bus.result !== ex[i]) begin n_fail++; $display("FAIL fast_result[%0d]: got %h expected %h", i, bus.result, ex[i]); end
      n_tests++; if (bus.busy !== 1'b1 || bus.result_rd !== 5'(20 + i)) begin n_fail++; $display("FAIL fast_hold[%0d]: busy %b rd %0d expected 1 %0d", i, bus.busy, bus.result_rd, 20 + i); end
      take();
    end
  endtask

  task automatic test_illegal_and_idle_flush();
    bus.valid_in = 1'b1; bus.funct3 = 3'b010; bus.rs1_data = 32'd9; bus.rs2_data = 32'd3; bus.rd_addr = 5'd1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.div_start !== 1'b0) begin n_fail++; $display("FAIL illegal_accept: busy %b start %b expected 0 0", bus.busy, bus.div_start); end
    bus.funct3 = 3'b101; bus.flush = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_flush_ready: got %b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.flush = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_flush_accept: busy %b expected 0", bus.busy); end
  endtask

  task automatic test_flush();
    int cyc, sc, ns; logic sgn, saw;
    logic [31:0] a, b;
    // Flush in START: start still issued, divider drained
    div_lat = 33;
    issue(3'b101, 32'd1000, 32'd3, 5'd9);
    bus.flush = 1'b1;
    n_tests++; if (bus.div_start !== 1'b1) begin n_fail++; $display("FAIL flush_start_pulse: got %b expected 1", bus.div_start); end
    @(posedge clk); #1; bus.flush = 1'b0;
    cyc = 2; saw = 1'b0;
    while (bus.busy && cyc < 120) begin saw |= bus.result_valid; @(posedge clk); #1; cyc++; end
    n_tests++; if (cyc !== 35 || saw !== 1'b0) begin n_fail++; $display("FAIL flush_start_drain: idle at %0d valid_seen %b expected 35 0", cyc, saw); end
    // Flush in WAIT at cycle 10
    issue(3'b101, 32'd1000, 32'd3, 5'd9);
    cyc = 1; saw = 1'b0;
    while (cyc < 10) begin saw |= bus.result_valid; @(posedge clk); #1; cyc++; end
    bus.flush = 1'b1; @(posedge clk); #1; bus.flush = 1'b0; cyc++;
    while (bus.busy && cyc < 120) begin saw |= bus.result_valid; @(posedge clk); #1; cyc++; end
    n_tests++; if (cyc !== 35 || saw !== 1'b0) begin n_fail++; $display("FAIL flush_wait_drain: idle at %0d valid_seen %b expected 35 0", cyc, saw); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_wait_ready: got %b expected 1", bus.in_ready); end
    a = $urandom(); b = $urandom_range(1, 5000);
    issue(3'b100, a, b, 5'd17);
    wait_result(cyc, sc, ns, sgn);
    n_tests++; if (bus.result !== ref_div(3'b100, a, b) || cyc !== 35) begin n_fail++; $display("FAIL flush_next_op: got %h at %0d expected %h at 35", bus.result, cyc, ref_div(3'b100, a, b)); end
    take();
  endtask

  task automatic test_hold();
    int cyc, sc, ns; logic sgn;
    issue(3'b101, 32'd500, 32'd9, 5'd11);
    wait_result(cyc, sc, ns, sgn);
    for (int i = 0; i < 5; i++) begin
      n_tests++; if ({bus.result_valid, bus.busy, bus.result, bus.result_rd} !== {2'b11, 32'd55, 5'd11}) begin
        n_fail++; $display("FAIL hold_stable[%0d]: valid %b busy %b result %h rd %0d expected 1 1 00000037 11", i, bus.result_valid, bus.busy, bus.result, bus.result_rd);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    n_tests++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL hold_flush_drop: valid %b busy %b expected 0 0", bus.result_valid, bus.busy); end
  endtask

  task automatic test_timeout();
    int cyc, n_err, err_cyc; logic saw, busy_at_err;
    tie_off = 1'b1; div_lat = 33;
    issue(3'b111, 32'd77, 32'd5, 5'd2);
    n_err = 0; err_cyc = -1; saw = 1'b0; busy_at_err = 1'b1;
    for (cyc = 1; cyc <= 60; cyc++) begin
      saw |= bus.result_valid;
      if (bus.err_timeout) begin n_err++; err_cyc = cyc; busy_at_err = bus.busy; end
      @(posedge clk); #1;
    end
    tie_off = 1'b0;
    n_tests++; if (n_err !== 1 || err_cyc !== 42) begin n_fail++; $display("FAIL timeout_pulse: count %0d at %0d expected 1 at 42", n_err, err_cyc); end
    n_tests++; if (saw !== 1'b0 || busy_at_err !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_idle: valid_seen %b busy %b in_ready %b expected 0 0 1", saw, busy_at_err, bus.in_ready); end
  endtask

  task automatic test_reset_in_wait();
    logic [106:0] obs;
    issue(3'b100, 32'hDEAD_BEEF, 32'd13, 5'd30);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    obs = {bus.in_ready, bus.result_valid, bus.busy, bus.err_timeout, bus.div_start, bus.div_signed,
           bus.result_rd, bus.result, bus.div_dividend, bus.div_divisor};
    n_tests++; if (obs !== 107'd0) begin n_fail++; $display("FAIL reset_wait_outputs: got %h expected 0", obs); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({bus.in_ready, bus.busy} !== 2'b10) begin n_fail++; $display("FAIL reset_wait_idle: in_ready/busy got %b expected 10", {bus.in_ready, bus.busy}); end
  endtask

  task automatic test_random();
    int cyc, sc, ns, exp_cyc; logic sgn;
    logic [2:0] f3; logic [31:0] a, b, ex; logic [4:0] rd;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      a  = $urandom(); b = $urandom(); rd = 5'($urandom());
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        default: a = $urandom_range(0, 100000);
      endcase
      div_lat = $urandom_range(2, 36);
      ex = ref_div(f3, a, b);
      exp_cyc = (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : div_lat + 2;
      issue(f3, a, b, rd);
      wait_result(cyc, sc, ns, sgn);
      n_tests++; if (bus.result !== ex || bus.result_rd !== rd) begin n_fail++; $display("FAIL rand_result[%0d]: f3 %b a %h b %h got %h rd %0d expected %h rd %0d", i, f3, a, b, bus.result, bus.result_rd, ex, rd); end
      n_tests++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, cyc, exp_cyc); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      take();
    end
  endtask

  initial begin
    bus.valid_in = 1'b0; bus.funct3 = 3'b000; bus.rs1_data = 32'd0; bus.rs2_data = 32'd0;
    bus.rd_addr = 5'd0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    reset = 1'b1;
    test_reset();
    test_normal();
    test_fast_path();
    test_illegal_and_idle_flush();
    test_flush();
    test_hold();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
